// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: aligned, byte-enabled req/ack transactions,
// load alignment/extension, pipeline stall, misalignment detection and bus timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_read_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  size_t       req_size, op_size;
  logic        req_signed, op_signed;
  logic        op_we;
  logic [1:0]  op_off;
  logic [29:0] op_addr;
  logic [3:0]  op_be, req_be;
  logic [31:0] op_wdata, req_wdata;
  logic [15:0] wait_cnt;
  logic        is_access, is_misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign is_access = valid_i & (mem_read_i | mem_write_i);

  // Stores only know SB/SH/SW; the unsigned load encodings fall back to word for stores.
  always_comb begin
    req_size   = SZ_WORD;
    req_signed = 1'b0;
    if (mem_write_i) begin
      case (funct3_i)
        3'b000:  req_size = SZ_BYTE;
        3'b001:  req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end else begin
      case (funct3_i)
        3'b000: begin req_size = SZ_BYTE; req_signed = 1'b1; end
        3'b001: begin req_size = SZ_HALF; req_signed = 1'b1; end
        3'b100:  req_size = SZ_BYTE;
        3'b101:  req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr_i[1:0];
        req_wdata = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << addr_i[1:0];
        req_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = store_data_i;
      end
    endcase
  end

  always_comb begin
    case (req_size)
      SZ_HALF: is_misaligned = addr_i[0];
      SZ_WORD: is_misaligned = (addr_i[1:0] != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_byte = dmem_rdata_i[{op_off, 3'b000} +: 8];
    lane_half = dmem_rdata_i[{op_off[1], 4'b0000} +: 16];
    case (op_size)
      SZ_BYTE: load_ext = {{24{op_signed & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = {{16{op_signed & lane_half[15]}}, lane_half};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    misaligned_o = 1'b0;
    case (state)
      IDLE: begin
        if (is_access) begin
          if (is_misaligned) begin
            misaligned_o = 1'b1;
          end else begin
            stall_o    = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_ack_i || wait_cnt == LAST_WAIT) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields come only from the latched copy so they stay stable until ack.
  always_comb begin
    dmem_we_o    = dmem_req_o & op_we;
    dmem_addr_o  = dmem_req_o ? {op_addr, 2'b00} : '0;
    dmem_be_o    = dmem_req_o ? op_be : '0;
    dmem_wdata_o = dmem_req_o ? op_wdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we           <= 1'b0;
      op_off          <= '0;
      op_size         <= SZ_WORD;
      op_signed       <= 1'b0;
      op_addr         <= '0;
      op_be           <= '0;
      op_wdata        <= '0;
      wait_cnt        <= '0;
      mem_read_data_o <= '0;
      bus_err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_access && !is_misaligned) begin
            op_we     <= mem_write_i;
            op_off    <= addr_i[1:0];
            op_size   <= req_size;
            op_signed <= req_signed;
            op_addr   <= addr_i[31:2];
            op_be     <= mem_write_i ? req_be : '0;
            op_wdata  <= req_wdata;
            wait_cnt  <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            if (!op_we) mem_read_data_o <= load_ext;
          end else if (wait_cnt == LAST_WAIT) begin
            bus_err_o       <= 1'b1;
            mem_read_data_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE:    bus_err_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level model drives per-cycle
// expectations, one negedge process compares every output against them.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk, rst;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] mem_read_data_o;
  logic        stall_o, misaligned_o, bus_err_o;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_read_data_o(mem_read_data_o), .stall_o(stall_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle, set by the stimulus side.
  logic        e_req, e_stall, e_mis, e_err, e_we, e_chk_wdata;
  logic [31:0] e_addr, e_wdata, model_rd;
  logic [3:0]  e_be;
  int          req_cnt, stall_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dmem_req_o === 1'b1) begin
      req_cnt++;
      cap_addr  = dmem_addr_o;
      cap_be    = dmem_be_o;
      cap_wdata = dmem_wdata_o;
      cap_we    = dmem_we_o;
    end
    if (stall_o === 1'b1) stall_cnt++;
    check("req", {31'd0, dmem_req_o}, {31'd0, e_req});
    check("stall", {31'd0, stall_o}, {31'd0, e_stall});
    check("misaligned", {31'd0, misaligned_o}, {31'd0, e_mis});
    check("bus_err", {31'd0, bus_err_o}, {31'd0, e_err});
    check("read_data", mem_read_data_o, model_rd);
    if (e_req) begin
      check("we", {31'd0, dmem_we_o}, {31'd0, e_we});
      check("addr", dmem_addr_o, e_addr);
      check("be", {28'd0, dmem_be_o}, {28'd0, e_be});
      if (e_chk_wdata) check("wdata", dmem_wdata_o, e_wdata);
    end
  end

  // Access size in bytes from the instruction encoding.
  function automatic int f_size(input bit wr, input logic [2:0] f3);
    if (f3 == 3'b000 || (!wr && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!wr && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = f_size(1'b0, f3);
    if (sz == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    dmem_ack_i = 1'b0;
    e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0;
  endtask

  // One memory instruction from IDLE; lat = ACCESS cycle carrying ack (0 = never).
  task automatic op(input bit wr, input bit both, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] sd,
                    input int lat, input logic [31:0] rdat);
    int  sz;
    bit  mis, acked;
    sz  = f_size(wr, f3);
    mis = (a % sz) != 0;
    req_cnt = 0; stall_cnt = 0;
    valid_i = 1'b1; mem_write_i = wr; mem_read_i = !wr || both;
    funct3_i = f3; addr_i = a; store_data_i = sd;
    dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
    e_req = 1'b0; e_stall = !mis; e_mis = mis; e_err = 1'b0;
    tick();
    if (!mis) begin
      acked = 1'b0;
      e_req = 1'b1; e_stall = 1'b1; e_mis = 1'b0; e_we = wr;
      e_addr = a & 32'hFFFFFFFC;
      e_be = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'h0;
      e_wdata = (sz == 1) ? sd[7:0] * 32'h01010101 :
                (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
      e_chk_wdata = wr;
      // Stalled EX/MEM inputs are scrambled here; the access must use its latched copy.
      addr_i = ~a; store_data_i = ~sd; funct3_i = f3 ^ 3'b111;
      for (int j = 1; j <= TO && !acked; j++) begin
        dmem_ack_i = (j == lat);
        dmem_rdata_i = (j == lat) ? rdat : $urandom;
        if (j == lat) acked = 1'b1;
        tick();
      end
      if (!acked) model_rd = 32'h0;
      else if (!wr) model_rd = f_load(f3, a, rdat);
      addr_i = a; store_data_i = sd; funct3_i = f3;
      dmem_ack_i = 1'b1; dmem_rdata_i = $urandom;
      e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_err = !acked;
      tick();
    end
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b0;
    addr_i = '0; store_data_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0; e_chk_wdata = 1'b0;
    model_rd = '0; req_cnt = 0; stall_cnt = 0;
    cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_we = 1'b0;
    set_idle();
    tick(); tick();
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_be", {28'd0, dmem_be_o}, 32'd0);
    check("rst_wdata", dmem_wdata_o, 32'd0);
    check("rst_rdata", mem_read_data_o, 32'd0);
    rst = 1'b0;
    tick();

    // LW, ack on first ACCESS cycle; stray ack while idle beforehand
    dmem_ack_i = 1'b1; tick(); dmem_ack_i = 1'b0;
    op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    check("lw_data", mem_read_data_o, 32'hDEADBEEF);
    check("lw_req_cycles", req_cnt, 32'd1);
    check("lw_stall_cycles", stall_cnt, 32'd2);

    op(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80123456);
    check("lb_data", mem_read_data_o, 32'hFFFFFF80);
    op(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80123456);
    check("lbu_data", mem_read_data_o, 32'h00000080);
    op(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80123456);
    check("lh_data", mem_read_data_o, 32'hFFFF8012);
    op(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80123456);
    check("lhu_data", mem_read_data_o, 32'h00008012);
    op(1'b0, 1'b0, 3'b001, 32'h100, 32'h0, 2, 32'h1234F00D);
    check("lh_low_data", mem_read_data_o, 32'hFFFFF00D);
    op(1'b0, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h00007F00);
    check("lb_pos_data", mem_read_data_o, 32'h0000007F);

    op(1'b1, 1'b0, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0);
    check("sb_addr", cap_addr, 32'h200);
    check("sb_be", {28'd0, cap_be}, 32'h2);
    check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    check("sb_keeps_rdata", mem_read_data_o, 32'h0000007F);
    op(1'b1, 1'b0, 3'b001, 32'h202, 32'h00001234, 2, 32'h0);
    check("sh_be", {28'd0, cap_be}, 32'hC);
    check("sh_wdata", cap_wdata, 32'h12341234);
    op(1'b1, 1'b1, 3'b010, 32'h204, 32'hCAFEBABE, 1, 32'h0);
    check("sw_both_we", {31'd0, cap_we}, 32'd1);
    check("sw_be", {28'd0, cap_be}, 32'hF);

    op(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h11111111);
    check("mis_lw_req", req_cnt, 32'd0);
    check("mis_lw_stall", stall_cnt, 32'd0);
    op(1'b1, 1'b0, 3'b001, 32'h001, 32'hFFFF, 1, 32'h0);
    check("mis_sh_req", req_cnt, 32'd0);
    op(1'b0, 1'b0, 3'b101, 32'h103, 32'h0, 1, 32'h22222222);
    check("mis_keeps_rdata", mem_read_data_o, 32'h0000007F);

    op(1'b0, 1'b0, 3'b011, 32'h108, 32'h0, 1, 32'h87654321);
    check("f3_other_word", mem_read_data_o, 32'h87654321);
    op(1'b0, 1'b0, 3'b010, 32'h10C, 32'h0, TO, 32'h0BADF00D);
    check("ack_last_cycle", mem_read_data_o, 32'h0BADF00D);

    op(1'b0, 1'b0, 3'b010, 32'h110, 32'h0, 0, 32'h0);
    check("timeout_req_cycles", req_cnt, 32'd4);
    check("timeout_stall_cycles", stall_cnt, 32'd5);
    check("timeout_rdata", mem_read_data_o, 32'h0);
    op(1'b0, 1'b0, 3'b010, 32'h114, 32'h0, 1, 32'h5A5A5A5A);
    check("after_timeout", mem_read_data_o, 32'h5A5A5A5A);

    // Reset during the third wait cycle
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h300;
    e_stall = 1'b1;
    tick();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'h0; e_chk_wdata = 1'b0;
    tick(); tick();
    check("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
    rst = 1'b1;
    model_rd = '0;
    set_idle();
    #1;
    check("rst_mid_req_drop", {31'd0, dmem_req_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'h13572468);
    check("post_rst_lw", mem_read_data_o, 32'h13572468);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
